multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- FSM controller that sequences the shared multi-cycle 16-bit datapath: PC, instruction register (IR), register file, one ALU, and one unified memory port.
- Per-instruction control is decoded from the latched IR opcode/func and the current state.
- Replaces single-cycle decode; the ALU and memory port are reused across IF/ID/EX/MEM/WB.
- Sits between the IR and the datapath muxes/enables inside cpu.

Parameters:
WORD_SIZE, 16, datapath/instruction width
STATE_W, 3, state register width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  4  IR[15:12]
func_code  in  6  IR[5:0]
branch_cond  in  1  ALU branch-taken flag for current B-type op
mem_ready  in  1  memory completes current read/write this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  latch memory data into IR
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update iff branch_cond
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[15:12],IR[11:0]}, 11 register rs
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 constant 1, 10 sign-extended imm, 11 zero-extended imm
alu_op  out  3  FUNC_* code
reg_dst  out  2  00 rd, 01 rt, 10 $2
reg_src  out  2  00 ALUOut, 01 MDR, 10 PC (link)
reg_write  out  1  register file write enable
is_wwd  out  1  WWD output strobe
inst_done  out  1  one-cycle pulse on the final cycle of each instruction
halted  out  1  HLT executed

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Registered state; outputs are combinational from state + opcode/func + mem_ready.
- Reset:
  - While reset=1, all outputs are forced to 0.
  - The next state is IF; any in-flight memory request is abandoned.
  - Reset in HALT also returns to IF.
- IF:
  - Drives mem_read=1, i_or_d=0.
  - Stays in IF while mem_ready=0.
  - When mem_ready=1: ir_write=1; pc_write=1 with pc_source=00, alu_src_a=0, alu_src_b=01, ADD (PC+1); next state ID.
- ID:
  - Computes the branch target PC+sext(imm) into ALUOut (alu_src_a=0, b=10, ADD).
  - Next state EX.
- EX by class:
  - R-type ALU (opcode 15, func 0-7): alu_src_a=1, b=00, alu_op per func. Next WB.
  - ADI: ADD, b=10. ORI: ORR, b=11. LHI: SHL, b=11. Next WB.
  - LWD/SWD: ADD, b=10. Next MEM.
  - BNE/BEQ/BGZ/BLZ: SUB, a=1, b=00; pc_write_cond=1, pc_source=01; inst_done=1. Next IF.
  - JMP: pc_write=1, pc_source=10. JAL additionally sets reg_write=1, reg_dst=10, reg_src=10. inst_done=1. Next IF.
  - JPR: pc_write=1, pc_source=11. JRL additionally sets reg_write=1, reg_dst=10, reg_src=10. inst_done=1. Next IF.
  - WWD: is_wwd=1 for exactly one cycle, inst_done=1. Next IF.
  - HLT: inst_done=1. Next HALT.
  - Undefined opcode/func: NOP, inst_done=1. Next IF.
- MEM:
  - i_or_d=1; mem_read=1 for LWD, mem_write=1 for SWD. Hold until mem_ready=1.
  - LWD then goes to WB.
  - SWD: inst_done=1, then IF.
- WB:
  - reg_write=1, inst_done=1. Next IF.
  - reg_dst=00 for R-type, 01 otherwise. reg_src=01 for LWD, 00 otherwise.
- HALT: halted=1; all other outputs 0; absorbing until reset.
- Link value: PC at EX is already PC+1, so the link register write captures the return address.
- Latency with mem_ready tied high:
  - R/I-type: 4 cycles.
  - LWD: 5 cycles.
  - SWD: 4 cycles.
  - Branch, jump, WWD, HLT: 3 cycles.
- Each mem_ready-low cycle in IF or MEM adds one cycle.
- mem_read and mem_write are never both 1; neither is asserted outside IF/MEM.

Optional Feature:
JUMP_IN_ID_EN
- Defined:
  - JMP/JAL/JPR/JRL perform their PC update and link write in ID, assert inst_done there, and return to IF. Jump latency is 2 cycles.
  - WWD and HLT also complete in ID.
- Undefined: jumps complete in EX as specified above (3 cycles).

Decomposition:
- Opcode, func_code and FUNC_* ALU codes stay in the shared opcodes.v include.
- Add to the shared include:
  - State encodings S_IF..S_HALT.
  - pc_source, alu_src_b, reg_dst and reg_src select codes.
- One natural sub-module, mc_decode: combinational classifier producing is_rtype, is_itype, is_load, is_store, is_branch, is_jump, is_link, is_jreg, is_wwd, is_hlt from opcode/func. The FSM stays in multicycle_controller.

Test Plan:
- ADD (opcode 15, func 0), mem_ready=1 → states IF,ID,EX,WB; reg_write only in cycle 4 with reg_dst=00; inst_done once; ir_write once.
- LWD with mem_ready low for 2 extra cycles in both IF and MEM → 9 cycles total; reg_src=01 in WB; i_or_d=1 only in MEM.
- BEQ with branch_cond=0, then BEQ with branch_cond=1 → both 3 cycles; pc_write_cond=1 with pc_source=01 in EX each time.
- JAL → reg_write, reg_dst=10, reg_src=10 in EX, 3 cycles; with JUMP_IN_ID_EN, same outputs in ID, 2 cycles.
- WWD then HLT → is_wwd high exactly one cycle; halted stays 1 for 20 cycles with mem_read=0; reset returns to IF on the next cycle.
- Reset asserted while in MEM during an SWD stall → mem_write drops in the reset cycle; next state IF; no inst_done pulse.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_pkg
//  Description : Shared encodings for the multi-cycle 16-bit CPU: opcodes,
//                R-type func codes, ALU FUNC_* codes, controller state
//                encodings and datapath mux select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    localparam int WORD_SIZE = 16;
    localparam int STATE_W   = 3;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_BNE  = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BGZ  = 4'd2;
    localparam logic [3:0] OP_BLZ  = 4'd3;
    localparam logic [3:0] OP_ADI  = 4'd4;
    localparam logic [3:0] OP_ORI  = 4'd5;
    localparam logic [3:0] OP_LHI  = 4'd6;
    localparam logic [3:0] OP_LWD  = 4'd7;
    localparam logic [3:0] OP_SWD  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
    localparam logic [3:0] OP_RTYP = 4'd15;

    // Func codes (IR[5:0]) under OP_RTYP; 0-7 are ALU operations
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // ALU operation codes; R-type ALU func[2:0] maps directly onto these
    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_AND = 3'd2;
    localparam logic [2:0] FUNC_ORR = 3'd3;
    localparam logic [2:0] FUNC_NOT = 3'd4;
    localparam logic [2:0] FUNC_TCP = 3'd5;
    localparam logic [2:0] FUNC_SHL = 3'd6;
    localparam logic [2:0] FUNC_SHR = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_ONE  = 2'b01;
    localparam logic [1:0] ALU_B_SEXT = 2'b10;
    localparam logic [1:0] ALU_B_ZEXT = 2'b11;

    localparam logic [1:0] REG_DST_RD = 2'b00;
    localparam logic [1:0] REG_DST_RT = 2'b01;
    localparam logic [1:0] REG_DST_R2 = 2'b10;

    localparam logic [1:0] REG_SRC_ALUOUT = 2'b00;
    localparam logic [1:0] REG_SRC_MDR    = 2'b01;
    localparam logic [1:0] REG_SRC_PC     = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Control bundle between the multi-cycle controller and the
//                datapath. master = controller, slave = datapath.
//                Datapath -> controller : opcode, func_code, branch_cond,
//                                         mem_ready
//                Controller -> datapath : memory, PC, IR, ALU, register file
//                                         controls plus is_wwd/inst_done/halted
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    logic [3:0] opcode;
    logic [5:0] func_code;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       reg_write;
    logic       is_wwd;
    logic       inst_done;
    logic       halted;

    modport master (
        input  opcode, func_code, branch_cond, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, reg_src,
               reg_write, is_wwd, inst_done, halted
    );

    modport slave (
        output opcode, func_code, branch_cond, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, reg_src,
               reg_write, is_wwd, inst_done, halted
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Combinational instruction classifier for the latched IR.
//                Inputs : i_opcode (IR[15:12]), i_func_code (IR[5:0])
//                Outputs: one-hot-ish class flags; is_link qualifies a jump
//                         class. No flag set means undefined (executes as NOP).
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import multicycle_controller_pkg::*;
(
    input  wire logic [3:0] i_opcode,
    input  wire logic [5:0] i_func_code,
    output logic            o_is_rtype,
    output logic            o_is_itype,
    output logic            o_is_load,
    output logic            o_is_store,
    output logic            o_is_branch,
    output logic            o_is_jump,
    output logic            o_is_link,
    output logic            o_is_jreg,
    output logic            o_is_wwd,
    output logic            o_is_hlt
);
    logic w_rtyp;

    assign w_rtyp      = (i_opcode == OP_RTYP);
    assign o_is_rtype  = w_rtyp && (i_func_code[5:3] == 3'b000);
    assign o_is_itype  = (i_opcode == OP_ADI) || (i_opcode == OP_ORI) ||
                         (i_opcode == OP_LHI);
    assign o_is_load   = (i_opcode == OP_LWD);
    assign o_is_store  = (i_opcode == OP_SWD);
    assign o_is_branch = (i_opcode <= OP_BLZ);
    assign o_is_jump   = (i_opcode == OP_JMP) || (i_opcode == OP_JAL);
    assign o_is_jreg   = w_rtyp && ((i_func_code == FN_JPR) ||
                                    (i_func_code == FN_JRL));
    assign o_is_link   = (i_opcode == OP_JAL) ||
                         (w_rtyp && (i_func_code == FN_JRL));
    assign o_is_wwd    = w_rtyp && (i_func_code == FN_WWD);
    assign o_is_hlt    = w_rtyp && (i_func_code == FN_HLT);
endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : FSM sequencing the shared multi-cycle datapath through
//                IF/ID/EX/MEM/WB/HALT. Outputs are combinational from the
//                registered state, the latched IR fields and mem_ready.
//                Ports: clk, reset (synchronous, active-high),
//                       bus (multicycle_controller_if.master)
//                Option: define JUMP_IN_ID_EN to retire JMP/JAL/JPR/JRL,
//                        WWD and HLT in ID (2-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    multicycle_controller_if.master bus
);
    state_t     r_state;
    state_t     w_next_state;

    logic w_rtype, w_itype, w_load, w_store, w_branch;
    logic w_jump, w_link, w_jreg, w_wwd, w_hlt;
    logic w_short, w_short_in_id, w_short_now;

    logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write;
    logic       w_pc_write, w_pc_write_cond, w_alu_src_a, w_reg_write;
    logic       w_is_wwd, w_inst_done, w_halted;
    logic [1:0] w_pc_source, w_alu_src_b, w_reg_dst, w_reg_src;
    logic [2:0] w_alu_op;

    // The branch decision gates pc_write_cond inside the datapath.
    logic w_unused_branch_cond;
    assign w_unused_branch_cond = bus.branch_cond;

    mc_decode u_decode (
        .i_opcode    (bus.opcode),
        .i_func_code (bus.func_code),
        .o_is_rtype  (w_rtype),
        .o_is_itype  (w_itype),
        .o_is_load   (w_load),
        .o_is_store  (w_store),
        .o_is_branch (w_branch),
        .o_is_jump   (w_jump),
        .o_is_link   (w_link),
        .o_is_jreg   (w_jreg),
        .o_is_wwd    (w_wwd),
        .o_is_hlt    (w_hlt)
    );

    // Instructions needing no ALU/memory work after decode
    assign w_short = w_jump || w_jreg || w_wwd || w_hlt;
`ifdef JUMP_IN_ID_EN
    assign w_short_in_id = w_short;
`else
    assign w_short_in_id = 1'b0;
`endif
    assign w_short_now = ((r_state == S_EX) && w_short) ||
                         ((r_state == S_ID) && w_short_in_id);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_i_or_d        = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_source     = PC_SRC_ALU;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = ALU_B_REG;
        w_alu_op        = FUNC_ADD;
        w_reg_dst       = REG_DST_RD;
        w_reg_src       = REG_SRC_ALUOUT;
        w_reg_write     = 1'b0;
        w_is_wwd        = 1'b0;
        w_inst_done     = 1'b0;
        w_halted        = 1'b0;

        case (r_state)
            S_IF: begin
                // Fetch and PC+1 share the cycle the memory completes
                w_mem_read  = 1'b1;
                w_alu_src_b = ALU_B_ONE;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_ID;
                end
            end
            S_ID: begin
                // Speculative branch target PC+sext(imm) into ALUOut
                w_alu_src_b  = ALU_B_SEXT;
                w_next_state = S_EX;
            end
            S_EX: begin
                w_alu_src_a = 1'b1;
                if (w_rtype) begin
                    w_alu_op     = bus.func_code[2:0];
                    w_next_state = S_WB;
                end else if (w_itype) begin
                    w_alu_src_b  = (bus.opcode == OP_ADI) ? ALU_B_SEXT : ALU_B_ZEXT;
                    w_alu_op     = (bus.opcode == OP_ADI) ? FUNC_ADD :
                                   (bus.opcode == OP_ORI) ? FUNC_ORR : FUNC_SHL;
                    w_next_state = S_WB;
                end else if (w_load || w_store) begin
                    w_alu_src_b  = ALU_B_SEXT;
                    w_next_state = S_MEM;
                end else if (w_branch) begin
                    w_alu_op        = FUNC_SUB;
                    w_pc_write_cond = 1'b1;
                    w_pc_source     = PC_SRC_ALUOUT;
                    w_inst_done     = 1'b1;
                    w_next_state    = S_IF;
                end else begin
                    // Undefined encodings retire as NOP; short ones are
                    // completed below.
                    w_inst_done  = 1'b1;
                    w_next_state = S_IF;
                end
            end
            S_MEM: begin
                w_i_or_d    = 1'b1;
                w_mem_read  = w_load;
                w_mem_write = w_store;
                if (bus.mem_ready) begin
                    if (w_load) begin
                        w_next_state = S_WB;
                    end else begin
                        w_inst_done  = 1'b1;
                        w_next_state = S_IF;
                    end
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_inst_done  = 1'b1;
                w_reg_dst    = w_rtype ? REG_DST_RD : REG_DST_RT;
                w_reg_src    = w_load ? REG_SRC_MDR : REG_SRC_ALUOUT;
                w_next_state = S_IF;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = S_IF;
            end
        endcase

        // PC already holds PC+1 here, so the link write stores the return
        // address.
        if (w_short_now) begin
            w_inst_done  = 1'b1;
            w_next_state = w_hlt ? S_HALT : S_IF;
            if (w_jump || w_jreg) begin
                w_pc_write  = 1'b1;
                w_pc_source = w_jump ? PC_SRC_JUMP : PC_SRC_REG;
            end
            if (w_link) begin
                w_reg_write = 1'b1;
                w_reg_dst   = REG_DST_R2;
                w_reg_src   = REG_SRC_PC;
            end
            w_is_wwd = w_wwd;
        end

        if (reset) begin
            w_next_state    = S_IF;
            w_mem_read      = 1'b0;
            w_mem_write     = 1'b0;
            w_i_or_d        = 1'b0;
            w_ir_write      = 1'b0;
            w_pc_write      = 1'b0;
            w_pc_write_cond = 1'b0;
            w_pc_source     = 2'b00;
            w_alu_src_a     = 1'b0;
            w_alu_src_b     = 2'b00;
            w_alu_op        = 3'b000;
            w_reg_dst       = 2'b00;
            w_reg_src       = 2'b00;
            w_reg_write     = 1'b0;
            w_is_wwd        = 1'b0;
            w_inst_done     = 1'b0;
            w_halted        = 1'b0;
        end
    end

    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.ir_write      = w_ir_write;
    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.pc_source     = w_pc_source;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.reg_src       = w_reg_src;
    assign bus.reg_write     = w_reg_write;
    assign bus.is_wwd        = w_is_wwd;
    assign bus.inst_done     = w_inst_done;
    assign bus.halted        = w_halted;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. Each
//                instruction is expanded into its expected cycle-by-cycle
//                control trace from the instruction's class, then random
//                instruction streams with random memory stalls follow the
//                directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] reg_src;
        logic       is_wwd;
        logic       inst_done;
        logic       halted;
    } ctl_t;

    typedef enum int {
        K_R, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_BR,
        K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_HLT, K_UND
    } kind_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef JUMP_IN_ID_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic kind_t classify(input logic [3:0] op, input logic [5:0] fn);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return K_BR;
            4'd4:  return K_ADI;
            4'd5:  return K_ORI;
            4'd6:  return K_LHI;
            4'd7:  return K_LWD;
            4'd8:  return K_SWD;
            4'd9:  return K_JMP;
            4'd10: return K_JAL;
            4'd15: begin
                if (fn < 6'd8)   return K_R;
                if (fn == 6'd25) return K_JPR;
                if (fn == 6'd26) return K_JRL;
                if (fn == 6'd28) return K_WWD;
                if (fn == 6'd29) return K_HLT;
                return K_UND;
            end
            default: return K_UND;
        endcase
    endfunction

    function automatic ctl_t strobe_mask();
        ctl_t c = '0;
        c.mem_read = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1;
        c.ir_write = 1'b1; c.pc_write = 1'b1; c.pc_write_cond = 1'b1;
        c.reg_write = 1'b1; c.is_wwd = 1'b1; c.inst_done = 1'b1;
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic ctl_t alu_mask();
        ctl_t c = strobe_mask();
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 3'b111;
        return c;
    endfunction

    function automatic ctl_t short_exp(input kind_t k);
        ctl_t c = '0;
        c.inst_done = 1'b1;
        if (k == K_JMP || k == K_JAL) begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
        if (k == K_JPR || k == K_JRL) begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
        if (k == K_WWD) c.is_wwd = 1'b1;
        if (k == K_JAL || k == K_JRL) begin
            c.reg_write = 1'b1; c.reg_dst = 2'b10; c.reg_src = 2'b10;
        end
        return c;
    endfunction

    function automatic ctl_t short_mask(input kind_t k);
        ctl_t c = strobe_mask();
        if (k != K_WWD && k != K_HLT) c.pc_source = 2'b11;
        if (k == K_JAL || k == K_JRL) begin c.reg_dst = 2'b11; c.reg_src = 2'b11; end
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.mem_read = bus.mem_read;       c.mem_write = bus.mem_write;
        c.i_or_d = bus.i_or_d;           c.ir_write = bus.ir_write;
        c.pc_write = bus.pc_write;       c.pc_write_cond = bus.pc_write_cond;
        c.pc_source = bus.pc_source;     c.alu_src_a = bus.alu_src_a;
        c.alu_src_b = bus.alu_src_b;     c.alu_op = bus.alu_op;
        c.reg_write = bus.reg_write;     c.reg_dst = bus.reg_dst;
        c.reg_src = bus.reg_src;         c.is_wwd = bus.is_wwd;
        c.inst_done = bus.inst_done;     c.halted = bus.halted;
        return c;
    endfunction

    // Applies mem_ready for one cycle and checks the outputs mid-cycle.
    task automatic check_cycle(input logic rdy, input ctl_t e, input ctl_t m, input string tag);
        ctl_t o;
        bus.mem_ready = rdy;
        @(negedge clk);
        o = observe();
        tests++;
        assert ((o & m) === (e & m)) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (mask %h)", tag, o & m, e & m, m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string tag);
        reset = 1'b1;
        check_cycle(1'b1, '0, '1, tag);
        reset = 1'b0;
    endtask

    // Expected trace of one instruction from fetch to retirement.
    task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                             input int if_st, input int mem_st, input bit abort_in_mem,
                             input string name);
        kind_t k;
        ctl_t  e, m;
        bit    is_short;
        k = classify(op, fn);
        is_short = (k == K_JMP || k == K_JAL || k == K_JPR || k == K_JRL ||
                    k == K_WWD || k == K_HLT);
        bus.opcode = op; bus.func_code = fn; bus.branch_cond = bc;

        e = '0; e.mem_read = 1'b1; m = strobe_mask();
        for (int i = 0; i < if_st; i++) check_cycle(1'b0, e, m, {name, " IF stall"});
        e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b01;
        m = alu_mask(); m.pc_source = 2'b11;
        check_cycle(1'b1, e, m, {name, " IF"});

        if (is_short && EARLY) begin
            check_cycle(1'($urandom_range(0, 1)), short_exp(k), short_mask(k), {name, " ID done"});
            return;
        end
        e = '0; e.alu_src_b = 2'b10;
        check_cycle(1'($urandom_range(0, 1)), e, alu_mask(), {name, " ID"});

        if (is_short) begin
            check_cycle(1'($urandom_range(0, 1)), short_exp(k), short_mask(k), {name, " EX done"});
            return;
        end
        e = '0; m = alu_mask(); e.alu_src_a = 1'b1;
        case (k)
            K_R:   begin e.alu_src_b = 2'b00; e.alu_op = fn[2:0]; end
            K_ADI: begin e.alu_src_b = 2'b10; e.alu_op = 3'd0; end
            K_ORI: begin e.alu_src_b = 2'b11; e.alu_op = 3'd3; end
            K_LHI: begin e.alu_src_b = 2'b11; e.alu_op = 3'd6; end
            K_LWD, K_SWD: begin e.alu_src_b = 2'b10; e.alu_op = 3'd0; end
            K_BR:  begin
                e.alu_src_b = 2'b00; e.alu_op = 3'd1; e.pc_write_cond = 1'b1;
                e.pc_source = 2'b01; e.inst_done = 1'b1; m.pc_source = 2'b11;
            end
            default: begin e = '0; e.inst_done = 1'b1; m = strobe_mask(); end
        endcase
        check_cycle(1'($urandom_range(0, 1)), e, m, {name, " EX"});
        if (k == K_BR || k == K_UND) return;

        if (k == K_LWD || k == K_SWD) begin
            e = '0; m = strobe_mask(); e.i_or_d = 1'b1;
            e.mem_read = (k == K_LWD); e.mem_write = (k == K_SWD);
            for (int i = 0; i < mem_st; i++) check_cycle(1'b0, e, m, {name, " MEM stall"});
            if (abort_in_mem) begin
                reset_cycle({name, " reset in MEM"});
                return;
            end
            e.inst_done = (k == K_SWD);
            check_cycle(1'b1, e, m, {name, " MEM"});
            if (k == K_SWD) return;
        end

        e = '0; m = strobe_mask(); m.reg_dst = 2'b11; m.reg_src = 2'b11;
        e.reg_write = 1'b1; e.inst_done = 1'b1;
        e.reg_dst = (k == K_R) ? 2'b00 : 2'b01;
        e.reg_src = (k == K_LWD) ? 2'b01 : 2'b00;
        check_cycle(1'($urandom_range(0, 1)), e, m, {name, " WB"});
    endtask

    initial begin
        ctl_t        eh;
        logic [3:0]  op;
        logic [5:0]  fn;
        bus.opcode = 4'd0; bus.func_code = 6'd0;
        bus.branch_cond = 1'b0; bus.mem_ready = 1'b0;

        reset_cycle("reset");

        run_instr(4'd15, 6'd0, 1'b0, 0, 0, 1'b0, "ADD");
        run_instr(4'd7, 6'd3, 1'b0, 2, 2, 1'b0, "LWD stalls");
        run_instr(4'd1, 6'd5, 1'b0, 0, 0, 1'b0, "BEQ nt");
        run_instr(4'd1, 6'd5, 1'b1, 0, 0, 1'b0, "BEQ t");
        run_instr(4'd10, 6'd9, 1'b0, 0, 0, 1'b0, "JAL");
        run_instr(4'd15, 6'd26, 1'b0, 1, 0, 1'b0, "JRL");
        run_instr(4'd5, 6'd1, 1'b0, 0, 0, 1'b0, "ORI");
        run_instr(4'd6, 6'd2, 1'b0, 0, 0, 1'b0, "LHI");
        run_instr(4'd8, 6'd0, 1'b0, 0, 1, 1'b0, "SWD");
        run_instr(4'd12, 6'd0, 1'b0, 0, 0, 1'b0, "UNDEF op");
        run_instr(4'd15, 6'd40, 1'b0, 0, 0, 1'b0, "UNDEF fn");
        run_instr(4'd15, 6'd28, 1'b0, 0, 0, 1'b0, "WWD");
        run_instr(4'd15, 6'd29, 1'b0, 0, 0, 1'b0, "HLT");
        eh = '0; eh.halted = 1'b1;
        for (int i = 0; i < 20; i++) check_cycle(1'($urandom_range(0, 1)), eh, '1, "HALT hold");
        reset_cycle("reset in HALT");
        run_instr(4'd4, 6'd7, 1'b0, 0, 0, 1'b0, "ADI after halt");
        run_instr(4'd8, 6'd1, 1'b0, 1, 2, 1'b1, "SWD abort");
        run_instr(4'd15, 6'd1, 1'b0, 0, 0, 1'b0, "SUB after abort");

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            fn = 6'($urandom_range(0, 63));
            if (op == 4'd15) begin
                case ($urandom_range(0, 3))
                    0: fn = 6'd25;
                    1: fn = 6'd28;
                    2: fn = 6'($urandom_range(0, 7));
                    default: ;
                endcase
                if (fn == 6'd29) fn = 6'd26;
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
